// File: rtl/data_mem_pkg.sv
// Shared access-size encodings and lane helpers for the data_mem responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2,
    MEM_ACCESS_RSVD = 2'd3
  } mem_access_e;

  function automatic logic is_misaligned(input logic [1:0] acc, input logic [1:0] off);
    logic mis;
    case (mem_access_e'(acc))
      MEM_ACCESS_HALF: mis = off[0];
      MEM_ACCESS_WORD: mis = |off;
      MEM_ACCESS_RSVD: mis = 1'b1;
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] acc, input logic [1:0] off);
    logic [3:0] be;
    case (mem_access_e'(acc))
      MEM_ACCESS_BYTE: be = 4'b0001 << off;
      MEM_ACCESS_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      MEM_ACCESS_WORD: be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the low bytes puts the data on every lane; byte enables pick the live one.
  function automatic logic [31:0] lane_data(input logic [1:0] acc, input logic [31:0] wd);
    logic [31:0] d;
    case (mem_access_e'(acc))
      MEM_ACCESS_BYTE: d = {4{wd[7:0]}};
      MEM_ACCESS_HALF: d = {2{wd[15:0]}};
      default:         d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store bus between the control unit (master) and data_mem (slave).
interface data_mem_if;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        mem_wr_en_i;
  logic [1:0]  mem_acc_w_i;
  logic        mem_r_en_i;
  logic [1:0]  mem_acc_r_i;
  logic        mem_r_sext_i;
  logic        mem_wr_ready_o;
  logic [31:0] rd_data_o;
  logic        misalign_o;

  modport master (
    output addr_i, wr_data_i, mem_wr_en_i, mem_acc_w_i,
           mem_r_en_i, mem_acc_r_i, mem_r_sext_i,
    input  mem_wr_ready_o, rd_data_o, misalign_o
  );

  modport slave (
    input  addr_i, wr_data_i, mem_wr_en_i, mem_acc_w_i,
           mem_r_en_i, mem_acc_r_i, mem_r_sext_i,
    output mem_wr_ready_o, rd_data_o, misalign_o
  );
endinterface

// File: rtl/data_mem_sram.sv
// Single-port synchronous SRAM, 32-bit words, byte write enables, read-first registered read.
module data_mem_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  import data_mem_pkg::*;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] wmask;

  assign wmask   = be_mask(be_i);
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    if (we_i) mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
  end

endmodule

// File: rtl/data_mem.sv
// RV32I data-memory responder: sized loads/stores on a word SRAM.
// DATA_MEM_WBUF_EN adds a one-entry posted write buffer with load forwarding.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic       clk_i,
  input logic       rst_i,
  data_mem_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [AW-1:0] idx;
  logic          mis_w, mis_r, unused_addr, wr_ready;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata, merged;

  logic          ld_pend_q, ld_pend_d, ld_mis_q, ld_mis_d, sext_q, sext_d;
  logic [1:0]    off_q, off_d;
  mem_access_e   size_q, size_d;
  logic [31:0]   hold_q, hold_d, fmt, rd_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign idx         = bus.addr_i[AW+1:2];
  assign unused_addr = ^bus.addr_i[31:AW+2];
  assign mis_w       = is_misaligned(bus.mem_acc_w_i, bus.addr_i[1:0]);
  assign mis_r       = is_misaligned(bus.mem_acc_r_i, bus.addr_i[1:0]);
  assign st_be       = lane_be(bus.mem_acc_w_i, bus.addr_i[1:0]);
  assign st_data     = lane_data(bus.mem_acc_w_i, bus.wr_data_i);

  assign bus.misalign_o     = (bus.mem_wr_en_i & mis_w) | (bus.mem_r_en_i & mis_r);
  assign bus.mem_wr_ready_o = wr_ready;
  assign bus.rd_data_o      = rd_data;

`ifdef DATA_MEM_WBUF_EN
  logic          wbuf_valid_q, wbuf_valid_d, drain_now, accept;
  logic [AW-1:0] wbuf_idx_q, wbuf_idx_d;
  logic [3:0]    wbuf_be_q, wbuf_be_d, hit_q, hit_d;
  logic [31:0]   wbuf_data_q, wbuf_data_d, fwd_q, fwd_d;

  always_comb begin
    drain_now    = wbuf_valid_q & ~bus.mem_r_en_i;
    wr_ready     = ~wbuf_valid_q | drain_now;
    // Misaligned stores are acknowledged but never enter the buffer.
    accept       = bus.mem_wr_en_i & wr_ready & ~mis_w;
    wbuf_valid_d = accept | (wbuf_valid_q & ~drain_now);
    wbuf_idx_d   = accept ? idx     : wbuf_idx_q;
    wbuf_be_d    = accept ? st_be   : wbuf_be_q;
    wbuf_data_d  = accept ? st_data : wbuf_data_q;
    hit_d        = (wbuf_valid_q && (wbuf_idx_q == idx)) ? wbuf_be_q : '0;
    fwd_d        = wbuf_data_q;
    ram_we       = drain_now & ~rst_i;
    ram_be       = wbuf_be_q;
    ram_addr     = bus.mem_r_en_i ? idx : wbuf_idx_q;
    ram_wdata    = wbuf_data_q;
    merged       = (ram_rdata & ~be_mask(hit_q)) | (fwd_q & be_mask(hit_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wbuf_valid_q <= 1'b0;
    else       wbuf_valid_q <= wbuf_valid_d;
    wbuf_idx_q  <= wbuf_idx_d;
    wbuf_be_q   <= wbuf_be_d;
    wbuf_data_q <= wbuf_data_d;
    hit_q       <= hit_d;
    fwd_q       <= fwd_d;
  end
`else
  always_comb begin
    wr_ready  = ~bus.mem_r_en_i;
    ram_we    = bus.mem_wr_en_i & ~bus.mem_r_en_i & ~mis_w & ~rst_i;
    ram_be    = st_be;
    ram_addr  = idx;
    ram_wdata = st_data;
    merged    = ram_rdata;
  end
`endif

  data_mem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk_i   (clk_i),
    .re_i    (bus.mem_r_en_i),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Response formatting runs on the registered request; hold_q keeps the last result.
  always_comb begin
    byte_sel = 8'(merged >> {off_q, 3'b000});
    half_sel = 16'(merged >> {off_q[1], 4'b0000});
    case (size_q)
      MEM_ACCESS_BYTE: fmt = {{24{sext_q & byte_sel[7]}}, byte_sel};
      MEM_ACCESS_HALF: fmt = {{16{sext_q & half_sel[15]}}, half_sel};
      MEM_ACCESS_WORD: fmt = merged;
      default:         fmt = '0;
    endcase
    if (ld_mis_q) fmt = '0;
    rd_data   = ld_pend_q ? fmt : hold_q;
    hold_d    = rd_data;
    ld_pend_d = bus.mem_r_en_i;
    ld_mis_d  = mis_r;
    off_d     = bus.addr_i[1:0];
    size_d    = mem_access_e'(bus.mem_acc_r_i);
    sext_d    = bus.mem_r_sext_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      ld_pend_q <= ld_pend_d;
      hold_q    <= hold_d;
    end
    ld_mis_q <= ld_mis_d;
    off_q    <= off_d;
    size_q   <= size_d;
    sext_q   <= sext_d;
  end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed vector table, reset sequence, randomized traffic vs a byte-array model.
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if bus ();

  data_mem #(.DEPTH_WORDS(1024)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Architectural model: byte memory (byte address mod 4 KiB) plus buffer occupancy.
  logic [7:0]  mb [4096];
  bit          full;
  logic [31:0] exp_rd;
  logic [11:0] undo_a;
  logic [31:0] undo_w;
  logic        act_rdy, act_mis;
  logic [31:0] act_rd;

  typedef struct {
    logic        wr;
    logic [1:0]  aw;
    logic        rd;
    logic [1:0]  ar;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ck_rdy;
    logic        e_rdy;
    logic        e_mis;
    logic        ck_rd;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [1:0] aw, logic rd, logic [1:0] ar, logic sx,
                              logic [31:0] a, logic [31:0] wd, logic ck_rdy, logic e_rdy,
                              logic e_mis, logic ck_rd, logic [31:0] e_rd);
    vec_t v;
    v.wr = wr; v.aw = aw; v.rd = rd; v.ar = ar; v.sx = sx; v.a = a; v.wd = wd;
    v.ck_rdy = ck_rdy; v.e_rdy = e_rdy; v.e_mis = e_mis; v.ck_rd = ck_rd; v.e_rd = e_rd;
    return v;
  endfunction

  function automatic vec_t idle(logic ck_rd, logic [31:0] e_rd);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ck_rd, e_rd);
  endfunction

  function automatic bit ref_mis(logic [1:0] acc, logic [31:0] a);
    return (acc == 2'd3) || (acc == 2'd1 && a[0]) || (acc == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] acc, logic [31:0] a, logic sx);
    logic [31:0] v, t;
    int n;
    v = '0;
    if (ref_mis(acc, a)) return '0;
    n = 1 << acc;
    for (int k = 0; k < n; k++) v = v | (32'(mb[a[11:0] + 12'(k)]) << (8 * k));
    t = v >> (8 * n - 1);
    if (sx && n < 4 && t[0]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(logic [1:0] acc, logic [31:0] a, logic [31:0] wd);
    int n;
    n = 1 << acc;
    undo_a = {a[11:2], 2'b00};
    undo_w = ref_load(2'd2, {20'd0, undo_a}, 1'b0);
    for (int k = 0; k < n; k++) mb[a[11:0] + 12'(k)] = 8'(wd >> (8 * k));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic wr, logic [1:0] aw, logic rd, logic [1:0] ar, logic sx,
                       logic [31:0] a, logic [31:0] wd);
    bus.mem_wr_en_i  = wr;
    bus.mem_acc_w_i  = aw;
    bus.mem_r_en_i   = rd;
    bus.mem_acc_r_i  = ar;
    bus.mem_r_sext_i = sx;
    bus.addr_i       = a;
    bus.wr_data_i    = wd;
  endtask

  // One bus cycle: drive, sample at the falling edge, check against the model, advance the model.
  task automatic cycle(logic wr, logic [1:0] aw, logic rd, logic [1:0] ar, logic sx,
                       logic [31:0] a, logic [31:0] wd);
    logic e_mis, e_rdy;
    drive(wr, aw, rd, ar, sx, a, wd);
    @(negedge clk);
    act_rdy = bus.mem_wr_ready_o;
    act_mis = bus.misalign_o;
    act_rd  = bus.rd_data_o;
    e_mis = (wr && ref_mis(aw, a)) || (rd && ref_mis(ar, a));
`ifdef DATA_MEM_WBUF_EN
    e_rdy = !full || !rd;
`else
    e_rdy = !rd;
`endif
    chk("misalign", {31'd0, act_mis}, {31'd0, e_mis});
    chk("ready", {31'd0, act_rdy}, {31'd0, e_rdy});
    chk("rd_data", act_rd, exp_rd);
    if (rd) exp_rd = ref_load(ar, a, sx);
    if (wr && e_rdy && !ref_mis(aw, a)) begin
      ref_store(aw, a, wd);
`ifdef DATA_MEM_WBUF_EN
      full = 1'b1;
`endif
    end else if (!rd) begin
      full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (full) for (int k = 0; k < 4; k++) mb[undo_a + 12'(k)] = 8'(undo_w >> (8 * k));
    full   = 1'b0;
    exp_rd = '0;
  endtask

  initial begin
    logic [1:0]  aw, ar;
    logic [31:0] a, exp_after;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    full = 1'b0;
    exp_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("reset_rd_data", act_rd, 32'h0);
    chk("reset_ready", {31'd0, act_rdy}, 32'd1);
    chk("reset_misalign", {31'd0, act_mis}, 32'd0);

    // wr aw rd ar sx addr wd | ck_rdy e_rdy e_mis ck_rd e_rd
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h100, 32'hDEADBEEF, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h100, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h103, 32'h80, 1, 1, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h103, 0, 1, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h103, 0, 1, 0, 0, 1, 32'hFFFFFF80));
    tbl.push_back(idle(1, 32'h00000080));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h100, 0, 0, 0, 0, 1, 32'h00000080));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h100, 0, 0, 0, 0, 1, 32'h80ADBEEF));
    tbl.push_back(idle(1, 32'h80ADBEEF));
    tbl.push_back(idle(1, 32'h80ADBEEF));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h200, 32'h0000AAAA, 1, 1, 0, 1, 32'h80ADBEEF));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h114, 32'h5A5A5A5A, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h202, 32'h1234, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h200, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 32'h1234AAAA));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h110, 32'h11111111, 1, 1, 0, 1, 32'h1234AAAA));
    tbl.push_back(mk(1, 2, 1, 2, 0, 32'h114, 32'h22222222, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 2, 0, 32'h114, 32'h22222222, 1, 0, 0, 1, 32'h5A5A5A5A));
    tbl.push_back(mk(1, 2, 1, 2, 0, 32'h114, 32'h22222222, 1, 0, 0, 1, 32'h5A5A5A5A));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h114, 32'h22222222, 1, 1, 0, 1, 32'h5A5A5A5A));
    tbl.push_back(idle(1, 32'h5A5A5A5A));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h110, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h114, 0, 0, 0, 0, 1, 32'h11111111));
    tbl.push_back(idle(1, 32'h22222222));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h300, 32'hCAFEF00D, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h301, 0, 0, 0, 1, 0, 0));
    tbl.push_back(idle(1, 32'h0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 32'h302, 32'h55555555, 1, 1, 1, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h300, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 32'hCAFEF00D));
    tbl.push_back(mk(0, 0, 1, 3, 0, 32'h300, 0, 0, 0, 1, 0, 0));
    tbl.push_back(idle(1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h302, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h300, 0, 0, 0, 0, 1, 32'hFFFFCAFE));
    tbl.push_back(idle(1, 32'h0000F00D));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h301, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 32'hFFFFFFF0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h1000_0300, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 32'hCAFEF00D));

    foreach (tbl[i]) begin
      cycle(tbl[i].wr, tbl[i].aw, tbl[i].rd, tbl[i].ar, tbl[i].sx, tbl[i].a, tbl[i].wd);
      if (tbl[i].ck_rdy) chk($sformatf("tbl[%0d].ready", i), {31'd0, act_rdy}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl[%0d].misalign", i), {31'd0, act_mis}, {31'd0, tbl[i].e_mis});
      if (tbl[i].ck_rd) chk($sformatf("tbl[%0d].rd_data", i), act_rd, tbl[i].e_rd);
    end

    // Reset one cycle after a store is accepted: the buffered store must be dropped.
    cycle(1, 2, 0, 0, 0, 32'h400, 32'h0BADF00D);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 32'h400, 0);
    cycle(1, 2, 0, 0, 0, 32'h400, 32'h77777777);
    chk("pre_reset_rd_data", act_rd, 32'h0BADF00D);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("mid_reset_rd_data", act_rd, 32'h0);
    chk("mid_reset_ready", {31'd0, act_rdy}, 32'd1);
    cycle(0, 0, 1, 2, 0, 32'h400, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
`ifdef DATA_MEM_WBUF_EN
    exp_after = 32'h0BADF00D;
`else
    exp_after = 32'h77777777;
`endif
    chk("post_reset_word", act_rd, exp_after);

    // Randomized traffic on a 16-word window with random upper address bits (aliasing).
    for (int w = 0; w < 16; w++)
      cycle(1, 2, 0, 0, 0, ($urandom() & 32'hFFFF_F000) | (32'(w) << 2), $urandom());
    for (int it = 0; it < 1500; it++) begin
      aw = 2'($urandom_range(0, 2));
      ar = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) aw = 2'd3;
      if ($urandom_range(0, 9) == 0) ar = 2'd3;
      a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (aw == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (aw == 2'd1) a[1] = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), aw, 1'($urandom_range(0, 1)), ar,
            1'($urandom_range(0, 1)), a, $urandom());
    end
    cycle(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
